// File: rtl/batrider_snd_pkg.sv
`timescale 1ns/1ps
// Shared constants for the Batrider 68000 sound command port: register offsets,
// handshake FSM encoding and status byte layout.
package batrider_snd_pkg;

    localparam logic [3:0] OFS_LATCH     = 4'd0;
    localparam logic [3:0] OFS_LATCH2    = 4'd1;
    localparam logic [3:0] OFS_STAT_TRIG = 4'd2;
    localparam logic [3:0] OFS_IRQCLR    = 4'd3;

    localparam int STAT_WAIT_BIT = 0;
    localparam int STAT_IRQ_BIT  = 1;
    localparam int STAT_TMO_BIT  = 2;

    localparam int WDOG_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } snd_state_e;

    function automatic logic [7:0] status_byte(input logic tmo, input logic irq, input logic busy);
        logic [7:0] s;
        s                = 8'h00;
        s[STAT_TMO_BIT]  = tmo;
        s[STAT_IRQ_BIT]  = irq;
        s[STAT_WAIT_BIT] = busy;
        return s;
    endfunction

endpackage

// File: rtl/batrider_snd_wdog.sv
`timescale 1ns/1ps
// Handshake watchdog: counts cycles while run_i is high and flags expiry at
// TIMEOUT-1. Only instantiated when BATRIDER_SND_TIMEOUT_EN is defined.
module batrider_snd_wdog
    import batrider_snd_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    assign expired_o = run_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && !expired_o) begin
            cnt_d = cnt_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/batrider_snd_cmd.sv
`timescale 1ns/1ps
// batrider_snd_cmd: 68000-side sound command port feeding batrider_sound.
// Define BATRIDER_SND_TIMEOUT_EN to add a watchdog that force-releases a stalled handshake.
module batrider_snd_cmd
    import batrider_snd_pkg::*;
#(
    parameter int unsigned STROBE_LEN = 4
`ifdef BATRIDER_SND_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 4096
`endif
) (
    input  logic       CLK96,
    input  logic       RESET96,
    input  logic       M68K_CS,
    input  logic [3:0] M68K_ADDR,
    input  logic       M68K_RW,
    input  logic       M68K_LDSn,
    input  logic [7:0] M68K_DIN,
    output logic [7:0] M68K_DOUT,
    output logic       M68K_HOLD,
    output logic       M68K_IRQ4,
    output logic [7:0] SOUNDLATCH,
    output logic [7:0] SOUNDLATCH2,
    output logic       SND_CS,
    input  logic [7:0] SOUNDLATCH3,
    input  logic [7:0] SOUNDLATCH4,
    input  logic       WAIT,
    input  logic       SNDIRQ,
    output logic [1:0] STATE_DBG
);

    localparam int SCNT_W = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(STROBE_LEN - 1);

    snd_state_e        state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;

    logic       raw_prev_q;
    logic       acc_q;
    logic       sndirq_prev_q;
    logic       irq_q, irq_d;
    logic [7:0] latch_q, latch_d;
    logic [7:0] latch2_q, latch2_d;
    logic [7:0] dout_q, dout_d;

    logic raw_acc;
    logic acc_ok;
    logic wr_acc;
    logic rd_acc;
    logic hs_start;
    logic irq_clr;
    logic irq_set;
    logic wdog_expired;
    logic tmo_flag;

    // One access per bus cycle: only the rising edge of CS & ~LDSn counts.
    assign raw_acc = M68K_CS & ~M68K_LDSn;
    assign acc_ok  = acc_q && (state_q == ST_IDLE);
    assign wr_acc  = acc_ok && !M68K_RW;
    assign rd_acc  = acc_ok && M68K_RW;

    assign hs_start = wr_acc && ((M68K_ADDR == OFS_LATCH) ||
                                 (M68K_ADDR == OFS_LATCH2) ||
                                 (M68K_ADDR == OFS_STAT_TRIG));
    assign irq_clr  = wr_acc && (M68K_ADDR == OFS_IRQCLR);
    assign irq_set  = SNDIRQ && !sndirq_prev_q;

`ifdef BATRIDER_SND_TIMEOUT_EN
    logic wdog_clear;
    logic tmo_q, tmo_d;

    assign wdog_clear = (state_q == ST_STROBE) && (state_d == ST_HOLD);

    batrider_snd_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i     (CLK96),
        .rst_i     (RESET96),
        .clear_i   (wdog_clear),
        .run_i     (state_q == ST_HOLD),
        .expired_o (wdog_expired)
    );

    always_comb begin
        tmo_d = tmo_q;
        if (wdog_expired) begin
            tmo_d = 1'b1;
        end else if (irq_clr) begin
            tmo_d = 1'b0;
        end
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_flag = tmo_q;
`else
    assign wdog_expired = 1'b0;
    assign tmo_flag     = 1'b0;
`endif

    // Handshake: SND_CS is high for STROBE_LEN cycles, the sound side holds WAIT
    // high while busy, and the 68k is stalled (HOLD) until WAIT is sampled low.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            state_q <= ST_IDLE;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_start) begin
                    state_d = ST_STROBE;
                    scnt_d  = SCNT_LOAD;
                end
            end
            ST_STROBE: begin
                if (scnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    scnt_d = scnt_q - SCNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!WAIT || wdog_expired) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Wait for the bus cycle to end so a long cycle is not re-counted.
                if (!M68K_CS) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        SND_CS    = 1'b0;
        M68K_HOLD = 1'b0;
        case (state_q)
            ST_STROBE: begin
                SND_CS    = 1'b1;
                M68K_HOLD = 1'b1;
            end
            ST_HOLD: begin
                M68K_HOLD = 1'b1;
            end
            default: begin
                SND_CS    = 1'b0;
                M68K_HOLD = 1'b0;
            end
        endcase
    end

    assign STATE_DBG = state_q;

    always_comb begin
        latch_d  = latch_q;
        latch2_d = latch2_q;
        dout_d   = dout_q;
        if (hs_start && (M68K_ADDR == OFS_LATCH)) begin
            latch_d = M68K_DIN;
        end
        if (hs_start && (M68K_ADDR == OFS_LATCH2)) begin
            latch2_d = M68K_DIN;
        end
        if (rd_acc) begin
            case (M68K_ADDR)
                OFS_LATCH:     dout_d = SOUNDLATCH3;
                OFS_LATCH2:    dout_d = SOUNDLATCH4;
                OFS_STAT_TRIG: dout_d = status_byte(tmo_flag, irq_q, WAIT);
                default:       dout_d = 8'hFF;
            endcase
        end
    end

    // A new SNDIRQ edge beats a simultaneous clear so no interrupt is lost.
    always_comb begin
        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            raw_prev_q    <= 1'b0;
            acc_q         <= 1'b0;
            sndirq_prev_q <= 1'b0;
            irq_q         <= 1'b0;
            latch_q       <= 8'h00;
            latch2_q      <= 8'h00;
            dout_q        <= 8'h00;
        end else begin
            raw_prev_q    <= raw_acc;
            acc_q         <= raw_acc && !raw_prev_q;
            sndirq_prev_q <= SNDIRQ;
            irq_q         <= irq_d;
            latch_q       <= latch_d;
            latch2_q      <= latch2_d;
            dout_q        <= dout_d;
        end
    end

    assign M68K_DOUT   = dout_q;
    assign M68K_IRQ4   = irq_q;
    assign SOUNDLATCH  = latch_q;
    assign SOUNDLATCH2 = latch2_q;

endmodule

// File: tb/tb_batrider_snd_cmd.sv
`timescale 1ns/1ps
// Testbench for batrider_snd_cmd: directed bus cycles with a scoreboard that
// checks each completed strobe and each HOLD release as the DUT presents them.
module tb_batrider_snd_cmd;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_cs, m_rw, m_ldsn;
  logic [3:0] m_addr;
  logic [7:0] m_din, m_dout;
  logic       hold, irq4, snd_cs;
  logic [7:0] sl1, sl2, sl3, sl4;
  logic       wait_i, sndirq;
  logic [1:0] state_dbg;

  int tests = 0;
  int fails = 0;

  logic [23:0] exp_q[$];
  logic [7:0]  tail_q[$];

  batrider_snd_cmd dut (
    .CLK96       (clk),
    .RESET96     (rst),
    .M68K_CS     (m_cs),
    .M68K_ADDR   (m_addr),
    .M68K_RW     (m_rw),
    .M68K_LDSn   (m_ldsn),
    .M68K_DIN    (m_din),
    .M68K_DOUT   (m_dout),
    .M68K_HOLD   (hold),
    .M68K_IRQ4   (irq4),
    .SOUNDLATCH  (sl1),
    .SOUNDLATCH2 (sl2),
    .SND_CS      (snd_cs),
    .SOUNDLATCH3 (sl3),
    .SOUNDLATCH4 (sl4),
    .WAIT        (wait_i),
    .SNDIRQ      (sndirq),
    .STATE_DBG   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops on every SND_CS falling edge and every HOLD release
  logic cs_prev = 1'b0;
  logic hold_prev = 1'b0;
  int   cs_cnt = 0;
  int   tail_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      cs_prev   = 1'b0;
      hold_prev = 1'b0;
      cs_cnt    = 0;
      tail_cnt  = 0;
    end else begin
      if (snd_cs) begin
        cs_cnt++;
      end else if (cs_prev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL strobe_unexpected: got %0h expected none", {sl1, sl2, 8'(cs_cnt)});
        end else begin
          check("strobe", {8'h00, sl1, sl2, 8'(cs_cnt)}, {8'h00, exp_q.pop_front()});
        end
        cs_cnt = 0;
      end
      if (hold && !wait_i && !snd_cs) tail_cnt++;
      if (hold_prev && !hold) begin
        if (tail_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL hold_release_unexpected: got tail %0d expected none", tail_cnt);
        end else begin
          check("hold_tail", 32'(tail_cnt), {24'h0, tail_q.pop_front()});
        end
        tail_cnt = 0;
      end
      cs_prev   = snd_cs;
      hold_prev = hold;
    end
  end

  // driver tasks: inputs change on the falling edge
  task automatic bus_drive(input logic [3:0] ofs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    m_cs   = 1'b1;
    m_ldsn = 1'b0;
    m_rw   = rw;
    m_addr = ofs;
    m_din  = d;
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_release();
    m_cs   = 1'b0;
    m_ldsn = 1'b1;
    m_rw   = 1'b1;
  endtask

  task automatic wait_hold_low(input int budget, input string name);
    int n;
    n = 0;
    while (hold && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_released"}, {31'h0, hold}, 32'h0);
  endtask

  task automatic do_read(input logic [3:0] ofs, input logic [7:0] exp, input string name);
    bus_drive(ofs, 1'b1, 8'h00);
    check(name, {24'h0, m_dout}, {24'h0, exp});
    check({name, "_nohold"}, {31'h0, hold}, 32'h0);
    bus_release();
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    m_cs   = 1'b0;
    m_ldsn = 1'b1;
    m_rw   = 1'b1;
    m_addr = 4'h0;
    m_din  = 8'h00;
    sl3    = 8'h00;
    sl4    = 8'h00;
    wait_i = 1'b0;
    sndirq = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_snd_cs", {31'h0, snd_cs}, 32'h0);
    check("rst_hold", {31'h0, hold}, 32'h0);
    check("rst_irq4", {31'h0, irq4}, 32'h0);
    check("rst_dout", {24'h0, m_dout}, 32'h0);
    check("rst_latch", {16'h0, sl1, sl2}, 32'h0);
    check("rst_state", {30'h0, state_dbg}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // write offset 0 with a long WAIT pulse
    exp_q.push_back({8'h5A, 8'h00, 8'd4});
    tail_q.push_back(8'd0);
    bus_drive(4'd0, 1'b0, 8'h5A);
    check("w0_latch", {24'h0, sl1}, 32'h5A);
    check("w0_cs_latency", {31'h0, snd_cs}, 32'h1);
    check("w0_hold", {31'h0, hold}, 32'h1);
    repeat (2) @(negedge clk);
    wait_i = 1'b1;
    repeat (200) @(negedge clk);
    check("w0_hold_during_wait", {31'h0, hold}, 32'h1);
    wait_i = 1'b0;
    @(negedge clk);
    check("w0_hold_after_wait", {31'h0, hold}, 32'h0);
    bus_release();
    @(negedge clk);

    // write offset 1 with WAIT never raised
    exp_q.push_back({8'h5A, 8'hC3, 8'd4});
    tail_q.push_back(8'd1);
    bus_drive(4'd1, 1'b0, 8'hC3);
    check("w1_latch2", {24'h0, sl2}, 32'hC3);
    wait_hold_low(20, "w1");
    bus_release();
    @(negedge clk);

    // reads
    sl3 = 8'h11;
    sl4 = 8'h22;
    do_read(4'd0, 8'h11, "rd_ofs0");
    do_read(4'd1, 8'h22, "rd_ofs1");
    do_read(4'd2, 8'h00, "rd_status");
    do_read(4'd7, 8'hFF, "rd_ofs7");

    // SNDIRQ pulse, clear racing a second pulse, plain clear
    @(negedge clk);
    sndirq = 1'b1;
    @(negedge clk);
    sndirq = 1'b0;
    check("irq_set", {31'h0, irq4}, 32'h1);
    repeat (5) @(negedge clk);
    check("irq_sticky", {31'h0, irq4}, 32'h1);
    do_read(4'd2, 8'h02, "rd_status_irq");
    @(negedge clk);
    m_cs   = 1'b1;
    m_ldsn = 1'b0;
    m_rw   = 1'b0;
    m_addr = 4'd3;
    m_din  = 8'h00;
    @(negedge clk);
    sndirq = 1'b1;
    @(negedge clk);
    sndirq = 1'b0;
    check("irq_set_wins", {31'h0, irq4}, 32'h1);
    bus_release();
    @(negedge clk);
    bus_drive(4'd3, 1'b0, 8'h00);
    check("irq_cleared", {31'h0, irq4}, 32'h0);
    check("irqclr_nohold", {31'h0, hold}, 32'h0);
    bus_release();
    @(negedge clk);

    // offset 2 trigger with WAIT stuck high
    wait_i = 1'b1;
    @(negedge clk);
    exp_q.push_back({8'h5A, 8'hC3, 8'd4});
    tail_q.push_back(8'd0);
    bus_drive(4'd2, 1'b0, 8'hEE);
`ifdef BATRIDER_SND_TIMEOUT_EN
    n = 0;
    while (hold && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("tmo_hold_cycles", 32'(n), 32'd4100);
    bus_release();
    @(negedge clk);
    do_read(4'd2, 8'h05, "rd_status_tmo");
    bus_drive(4'd3, 1'b0, 8'h00);
    bus_release();
    @(negedge clk);
    do_read(4'd2, 8'h01, "rd_status_tmo_clr");
    wait_i = 1'b0;
`else
    n = 0;
    repeat (10000) begin
      @(negedge clk);
      if (hold) n++;
    end
    check("hold_no_timeout", 32'(n), 32'd10000);
    wait_i = 1'b0;
    wait_hold_low(4, "stuck");
    bus_release();
    @(negedge clk);
    do_read(4'd2, 8'h00, "rd_status_notmo");
`endif

    // reset during STROBE, then a normal write
    @(negedge clk);
    bus_drive(4'd0, 1'b0, 8'hA5);
    check("pre_rst_cs", {31'h0, snd_cs}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_cs", {31'h0, snd_cs}, 32'h0);
    check("rst_mid_hold", {31'h0, hold}, 32'h0);
    check("rst_mid_latches", {16'h0, sl1, sl2}, 32'h0);
    bus_release();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back({8'h00, 8'h3C, 8'd4});
    tail_q.push_back(8'd1);
    bus_drive(4'd1, 1'b0, 8'h3C);
    check("post_rst_latch2", {24'h0, sl2}, 32'h3C);
    wait_hold_low(20, "post_rst");
    bus_release();
    repeat (5) @(negedge clk);

    check("strobe_q_drained", 32'(exp_q.size()), 32'd0);
    check("tail_q_drained", 32'(tail_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/batrider_snd_cmd.md
Name: batrider_snd_cmd

Overview:
- 68000-side sound command port, directly upstream of batrider_sound.
- Latches 68k command bytes into SOUNDLATCH/SOUNDLATCH2 and raises an SND_CS strobe, which batrider_sound edge-detects into Z80 NMI and WAIT.
- Stalls the 68k bus (DTACK hold) until the Z80 clears WAIT.
- Returns SOUNDLATCH3/4 to the 68k and converts the SNDIRQ pulse into a sticky level-4 interrupt.

Parameters:
- STROBE_LEN, 4, cycles SND_CS stays high per command (minimum 2).
- TIMEOUT, 4096, CLK96 cycles before a stalled handshake is force-released (used only with the optional feature).

Ports:
- CLK96  in  1  96 MHz system clock.
- RESET96  in  1  asynchronous, active-high reset.
- M68K_CS  in  1  decoded sound-region select, high for the whole bus cycle.
- M68K_ADDR  in  4  68k A[4:1], word offset inside the region.
- M68K_RW  in  1  1 = read, 0 = write.
- M68K_LDSn  in  1  low-byte data strobe, active low.
- M68K_DIN  in  8  68k write data, low byte.
- M68K_DOUT  out  8  read data.
- M68K_HOLD  out  1  DTACK stall request, active high.
- M68K_IRQ4  out  1  level-4 interrupt request, active high.
- SOUNDLATCH, SOUNDLATCH2  out  8 each  command bytes to the Z80.
- SND_CS  out  1  command strobe to batrider_sound CS.
- SOUNDLATCH3, SOUNDLATCH4  in  8 each  Z80 reply bytes.
- WAIT  in  1  sound-side busy flag.
- SNDIRQ  in  1  sound-side IRQ pulse.

Behaviour:
- Clocking and reset: single clock CLK96; all flops reset asynchronously by RESET96 (active high).
- Reset values: all outputs 0; state IDLE; irq_pending 0; timeout flag 0.
- Access detection: an access = rising edge of (M68K_CS & ~M68K_LDSn), registered. Exactly one access per bus cycle.
- Reads:
  - Offset 0 = SOUNDLATCH3; 1 = SOUNDLATCH4; 2 = status {5'b0, timeout_flag, irq_pending, WAIT}; others = 8'hFF.
  - M68K_DOUT is registered, valid 1 cycle after the access edge.
  - Reads never assert M68K_HOLD.
- Writes:
  - Offset 0 loads SOUNDLATCH, offset 1 loads SOUNDLATCH2, offset 2 loads nothing. Each starts the handshake.
  - Offset 3 clears irq_pending and timeout_flag, with no handshake.
  - Other offsets are ignored.
- FSM IDLE -> STROBE -> HOLD -> RELEASE -> IDLE:
  - IDLE: on a handshake write, latch the byte at the edge cycle, set M68K_HOLD, and go to STROBE next cycle.
  - STROBE: SND_CS = 1 for exactly STROBE_LEN cycles (down-counter), M68K_HOLD = 1, then HOLD.
  - HOLD: SND_CS = 0; stay until WAIT == 0, then go to RELEASE and drop M68K_HOLD. If WAIT never rose, the exit takes one cycle.
  - RELEASE: wait for M68K_CS == 0, then IDLE. This prevents a single long cycle from being re-counted as an access.
- Latency: first write edge to SND_CS high = 2 cycles. WAIT falling to M68K_HOLD low = 1 cycle.
- Accesses arriving outside IDLE (only possible under a misbehaving master) are dropped, and M68K_HOLD stays as is.
- SNDIRQ: a rising edge (registered previous value) sets irq_pending. If a set and an offset-3 clear happen in the same cycle, set wins. M68K_IRQ4 = irq_pending.
- Latches hold their value until the next write to the same offset.
- Reset asserted mid-handshake: SND_CS and M68K_HOLD drop immediately (asynchronously); latches return to 0.

Optional Feature:
- Macro: BATRIDER_SND_TIMEOUT_EN.
- Defined:
  - A 13-bit counter runs in HOLD.
  - On reaching TIMEOUT-1, go to RELEASE, set timeout_flag (status bit 2) and drop M68K_HOLD.
  - The counter clears on entering HOLD.
- Undefined:
  - No counter; HOLD waits indefinitely for WAIT low.
  - Status bit 2 reads 0.

Decomposition:
- Package batrider_snd_pkg holds:
  - offset constants OFS_LATCH = 0, OFS_LATCH2 = 1, OFS_STAT_TRIG = 2, OFS_IRQCLR = 3;
  - FSM state encoding (2 bits);
  - status bit positions.
- One sub-module, batrider_snd_wdog: the timeout counter with a clear/run/expired interface. It is instantiated only under BATRIDER_SND_TIMEOUT_EN.

Test Plan:
- Write offset 0, data 8'h5A, with WAIT pulsed high 3 cycles after SND_CS and low 200 cycles later -> SOUNDLATCH = 5A at edge+1; SND_CS high cycles 2..5; M68K_HOLD falls 1 cycle after WAIT falls.
- Write offset 1, data 8'hC3, with WAIT held 0 -> SOUNDLATCH2 = C3; SND_CS high 4 cycles; M68K_HOLD released 1 cycle after STROBE ends; SOUNDLATCH unchanged.
- SOUNDLATCH3 = 8'h11, SOUNDLATCH4 = 8'h22; read offsets 0, 1, 2 -> DOUT 11, 22, then status 8'h00; M68K_HOLD never asserted.
- SNDIRQ 1-cycle pulse -> M68K_IRQ4 = 1 and stays; write offset 3 in the same cycle as a second pulse -> IRQ stays 1; a later offset-3 write -> 0.
- With macro defined, WAIT stuck high -> M68K_HOLD drops after 4096 HOLD cycles and status reads 8'h05; without macro -> HOLD persists for 10000 cycles.
- Assert RESET96 during STROBE -> SND_CS, M68K_HOLD and latches read 0 the same cycle; a post-reset write completes normally.
